// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto a single-port memory, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority with LS winning ties.
//
// state | meaning
// IDLE  | no transaction; grant a requester and capture its command
// REQ   | mem_req asserted from holding registers until mem_gnt
// RSP   | waiting for mem_rvalid to return data to the owner
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arbState_t;

  arbState_t       state, stateNxt;
  logic [XLEN-1:0] holdAddr, holdWdata;
  logic            holdWe, holdOwnerLs;
  logic            grantIf, grantLs, pickLs;
  logic            ifRvalidQ, lsRvalidQ;
  logic [XLEN-1:0] ifRdataQ, lsRdataQ;

`ifdef ARB_ROUND_ROBIN_EN
  logic rrPreferLs;

  // Points at the port that should win the next tie: the one not granted last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrPreferLs <= 1'b0;
    end else if (grantIf) begin
      rrPreferLs <= 1'b1;
    end else if (grantLs) begin
      rrPreferLs <= 1'b0;
    end
  end

  always_comb begin
    pickLs = ls_req;
    if (ls_req && if_req) begin
      pickLs = rrPreferLs;
    end
  end
`else
  always_comb begin
    pickLs = ls_req;
  end
`endif

  always_comb begin
    stateNxt = state;
    grantIf  = 1'b0;
    grantLs  = 1'b0;
    case (state)
      IDLE: begin
        if (rst && (if_req || ls_req)) begin
          grantLs  = pickLs;
          grantIf  = !pickLs;
          stateNxt = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          stateNxt = RSP;
        end
      end
      RSP: begin
        if (mem_rvalid) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      holdAddr    <= '0;
      holdWdata   <= '0;
      holdWe      <= 1'b0;
      holdOwnerLs <= 1'b0;
    end else begin
      state <= stateNxt;
      if (grantLs) begin
        holdAddr    <= ls_addr;
        holdWe      <= ls_we;
        holdWdata   <= ls_wdata;
        holdOwnerLs <= 1'b1;
      end else if (grantIf) begin
        holdAddr    <= if_addr;
        holdWe      <= 1'b0;
        holdWdata   <= '0;
        holdOwnerLs <= 1'b0;
      end
    end
  end

  // Responses are routed to the captured owner only; a store keeps ls_rdata as it was.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifRvalidQ <= 1'b0;
      lsRvalidQ <= 1'b0;
      ifRdataQ  <= '0;
      lsRdataQ  <= '0;
    end else begin
      ifRvalidQ <= 1'b0;
      lsRvalidQ <= 1'b0;
      if (state == RSP && mem_rvalid) begin
        if (holdOwnerLs) begin
          lsRvalidQ <= 1'b1;
          if (!holdWe) begin
            lsRdataQ <= mem_rdata;
          end
        end else begin
          ifRvalidQ <= 1'b1;
          ifRdataQ  <= mem_rdata;
        end
      end
    end
  end

  assign if_gnt    = grantIf;
  assign ls_gnt    = grantLs;
  assign if_rvalid = ifRvalidQ;
  assign ls_rvalid = lsRvalidQ;
  assign if_rdata  = ifRdataQ;
  assign ls_rdata  = lsRdataQ;
  assign mem_req   = (state == REQ);
  assign mem_we    = (state == REQ) && holdWe;
  assign mem_addr  = holdAddr;
  assign mem_wdata = holdWdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a simple memory responder, and a response monitor.
// Tie-break expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          isLs;
    logic [31:0] data;
  } expT;
  expT expQ[$];

  int          gntDelay = 0;
  int          rspWait  = 0;
  int          waitCnt  = 0;
  int          rspCnt   = 0;
  logic [31:0] rspData  = '0;

  mem_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h080: return 32'hCAFEF00D;
      default: return {16'hD0D0, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input bit isLs, input logic [31:0] data);
    expT e;
    e.isLs = isLs;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #2;
  endtask

  task automatic waitGnt(input bit isLs, input string name);
    int n = 0;
    @(negedge clk);
    while (!(isLs ? ls_gnt : if_gnt) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, isLs ? ls_gnt : if_gnt}, 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, expQ.size(), 32'd0);
  endtask

  // Memory model: grants after gntDelay cycles of mem_req, answers 1+rspWait cycles later.
  always @(posedge clk) begin
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (rspCnt > 0) begin
      rspCnt--;
      if (rspCnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rspData;
      end
    end
    if (mem_req) begin
      if (waitCnt >= gntDelay) begin
        mem_gnt = 1'b1;
        waitCnt = 0;
        rspCnt  = 1 + rspWait;
        rspData = mem_we ? 32'h0BAD0BAD : memData(mem_addr);
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end
  end

  always @(negedge clk) begin : monitor
    expT e;
    if (if_gnt || ls_gnt) begin
      chk("single_gnt", {31'd0, if_gnt && ls_gnt}, 32'd0);
    end
    if (rst && (if_rvalid || ls_rvalid)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: if_rvalid=%0b ls_rvalid=%0b, none expected (t=%0t)",
                 if_rvalid, ls_rvalid, $time);
      end else begin
        e = expQ.pop_front();
        chk("rsp_port_ls", {31'd0, ls_rvalid}, {31'd0, e.isLs});
        chk("rsp_port_if", {31'd0, if_rvalid}, {31'd0, !e.isLs});
        chk("rsp_data", e.isLs ? ls_rdata : if_rdata, e.data);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit expSeq[4];
    int n;

    // Reset values, with requests present to show grants are suppressed
    #1 rst = 1'b0;
    if_req = 1'b1;
    ls_req = 1'b1;
    @(negedge clk);
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_ls_gnt", {31'd0, ls_gnt}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    if_req = 1'b0;
    ls_req = 1'b0;
    nextCyc();
    rst = 1'b1;

    // Lone fetch, minimum latency
    if_req  = 1'b1;
    if_addr = 32'h100;
    pushExp(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("lat_if_gnt_c0", {31'd0, if_gnt}, 32'd1);
    nextCyc();
    if_req = 1'b0;
    @(negedge clk);
    chk("lat_mem_req_c1", {31'd0, mem_req}, 32'd1);
    chk("lat_mem_addr_c1", mem_addr, 32'h100);
    chk("lat_mem_we_c1", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("lat_mem_req_c2", {31'd0, mem_req}, 32'd0);
    chk("lat_if_rvalid_c2", {31'd0, if_rvalid}, 32'd0);
    @(negedge clk);
    chk("lat_if_rvalid_c3", {31'd0, if_rvalid}, 32'd1);
    chk("lat_ls_rvalid_c3", {31'd0, ls_rvalid}, 32'd0);
    drain("lat_drain");
    nextCyc();

    // Load to establish a known ls_rdata
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h80;
    pushExp(1'b1, 32'hCAFEF00D);
    waitGnt(1'b1, "ld_gnt");
    nextCyc();
    ls_req = 1'b0;
    drain("ld_drain");
    nextCyc();

    // Store with mem_gnt delayed 3 cycles; inputs change after grant
    gntDelay = 3;
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h40;
    ls_wdata = 32'h12345678;
    pushExp(1'b1, 32'hCAFEF00D);
    @(negedge clk);
    chk("st_ls_gnt", {31'd0, ls_gnt}, 32'd1);
    nextCyc();
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = 32'h999;
    ls_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("st_mem_req", {31'd0, mem_req}, 32'd1);
      chk("st_mem_we", {31'd0, mem_we}, 32'd1);
      chk("st_mem_addr", mem_addr, 32'h40);
      chk("st_mem_wdata", mem_wdata, 32'h12345678);
    end
    @(negedge clk);
    chk("st_rsp_mem_req", {31'd0, mem_req}, 32'd0);
    chk("st_rsp_mem_we", {31'd0, mem_we}, 32'd0);
    chk("st_rsp_mem_addr_hold", mem_addr, 32'h40);
    chk("st_rsp_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    @(negedge clk);
    chk("st_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
    chk("st_ls_rdata_kept", ls_rdata, 32'hCAFEF00D);
    drain("st_drain");
    gntDelay = 0;
    nextCyc();

    // Spurious mem_rvalid while idle
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBADBAD00;
    @(negedge clk);
    chk("sp_idle_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("sp_idle_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("sp_idle_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    chk("sp_idle_mem_req2", {31'd0, mem_req}, 32'd0);
    chk("sp_idle_if_rdata", if_rdata, 32'hDEADBEEF);
    nextCyc();

    // Spurious mem_gnt while waiting for a response
    rspWait = 2;
    if_req  = 1'b1;
    if_addr = 32'h300;
    pushExp(1'b0, 32'hD0D00300);
    @(negedge clk);
    chk("sp_rsp_if_gnt", {31'd0, if_gnt}, 32'd1);
    nextCyc();
    if_req = 1'b0;
    nextCyc();
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("sp_rsp_mem_req_c2", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("sp_rsp_mem_req_c3", {31'd0, mem_req}, 32'd0);
    chk("sp_rsp_if_rvalid_c3", {31'd0, if_rvalid}, 32'd0);
    @(negedge clk);
    chk("sp_rsp_if_rvalid_c4", {31'd0, if_rvalid}, 32'd0);
    @(negedge clk);
    chk("sp_rsp_if_rvalid_c5", {31'd0, if_rvalid}, 32'd1);
    drain("sp_drain");
    nextCyc();

    // Reset during RSP; the late mem_rvalid must be ignored
    if_req  = 1'b1;
    if_addr = 32'h500;
    @(negedge clk);
    chk("ra_if_gnt", {31'd0, if_gnt}, 32'd1);
    nextCyc();
    if_req = 1'b0;
    nextCyc();
    rst = 1'b0;
    @(negedge clk);
    chk("ra_mem_req", {31'd0, mem_req}, 32'd0);
    chk("ra_mem_addr", mem_addr, 32'd0);
    chk("ra_if_rdata", if_rdata, 32'd0);
    chk("ra_ls_rdata", ls_rdata, 32'd0);
    chk("ra_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    nextCyc();
    rst = 1'b1;
    @(negedge clk);
    chk("ra_mem_req_c3", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("ra_if_rvalid_c4", {31'd0, if_rvalid}, 32'd0);
    @(negedge clk);
    chk("ra_if_rvalid_c5", {31'd0, if_rvalid}, 32'd0);
    chk("ra_mem_req_c5", {31'd0, mem_req}, 32'd0);
    rspWait = 0;
    nextCyc();
    if_req  = 1'b1;
    if_addr = 32'h100;
    pushExp(1'b0, 32'hDEADBEEF);
    waitGnt(1'b0, "ra_next_gnt");
    nextCyc();
    if_req = 1'b0;
    drain("ra_drain");
    chk("ra_next_if_rdata", if_rdata, 32'hDEADBEEF);
    nextCyc();

    // Both ports requesting continuously, from a fresh reset
    rst = 1'b0;
    nextCyc();
    rst = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    expSeq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    expSeq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      pushExp(expSeq[i], expSeq[i] ? 32'hD0D00200 : 32'hD0D00300);
    end
    if_addr = 32'h300;
    ls_addr = 32'h200;
    ls_we   = 1'b0;
    if_req  = 1'b1;
    ls_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(negedge clk);
      while (!(if_gnt || ls_gnt) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("tie_gnt_ls", {31'd0, ls_gnt}, {31'd0, expSeq[i]});
      chk("tie_gnt_if", {31'd0, if_gnt}, {31'd0, !expSeq[i]});
    end
    nextCyc();
    if_req = 1'b0;
    ls_req = 1'b0;
    drain("tie_drain");
    repeat (4) nextCyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data/address width in bits.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch read request, held until if_gnt.
REQ-005 if_addr  input  XLEN  fetch address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  one-cycle pulse, fetch response valid.
REQ-008 if_rdata  output  XLEN  fetch read data.
REQ-009 ls_req  input  1  load/store request, held until ls_gnt.
REQ-010 ls_we  input  1  1 = store, 0 = load.
REQ-011 ls_addr  input  XLEN  load/store address.
REQ-012 ls_wdata  input  XLEN  store data.
REQ-013 ls_gnt  output  1  load/store request accepted this cycle.
REQ-014 ls_rvalid  output  1  one-cycle pulse, load data valid or store acknowledged.
REQ-015 ls_rdata  output  XLEN  load read data.
REQ-016 mem_req  output  1  request to single-port memory.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_addr  output  XLEN  memory address.
REQ-019 mem_wdata  output  XLEN  memory write data.
REQ-020 mem_gnt  input  1  memory accepted mem_req this cycle.
REQ-021 mem_rvalid  input  1  memory response, one per accepted request, loads and stores alike.
REQ-022 mem_rdata  input  XLEN  memory read data, valid with mem_rvalid.

Function
REQ-023 FSM states IDLE, REQ, RSP; at most one memory transaction outstanding.
REQ-024 IDLE: any x_req -> select winner, assert its x_gnt combinationally in that cycle, capture addr/we/wdata/owner into holding registers, go to REQ.
REQ-025 IF captures force we=0 and wdata=0.
REQ-026 REQ: mem_req=1, mem_addr/mem_we/mem_wdata driven from holding registers, stable until mem_gnt; mem_gnt=1 -> RSP.
REQ-027 RSP: mem_req=0; mem_rvalid=1 -> register mem_rdata into owner's x_rdata, pulse owner's x_rvalid next cycle, go to IDLE.
REQ-028 x_rvalid and x_rdata registered; non-owner rvalid stays 0; x_rdata holds last value between responses; stores leave ls_rdata unchanged.
REQ-029 Minimum latency: x_req cycle 0 -> mem_req cycle 1 -> (mem_gnt 1) mem_rvalid cycle 2 -> x_rvalid cycle 3; new grant allowed in cycle 3.
REQ-030 At most one x_gnt per cycle; no x_gnt outside IDLE.
REQ-031 mem_gnt outside REQ and mem_rvalid outside RSP ignored.
REQ-032 Requester dropping x_req before its grant: no transaction.
REQ-033 Outside REQ, mem_we=0 and mem_addr/mem_wdata hold last values.

Reset
REQ-034 rst low: state=IDLE, holding registers=0, mem_req=0, mem_we=0, all x_gnt/x_rvalid=0, x_rdata=0, round-robin pointer=IF-next.
REQ-035 Reset mid-transaction aborts it; no x_rvalid produced for it afterward.

Configuration
REQ-036 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, LS wins simultaneous requests.
REQ-037 ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the port not granted last; pointer updates on every grant; after reset IF wins first tie.

Verification
REQ-038 Lone if_req addr 0x100, mem_gnt immediate, mem_rvalid next cycle rdata 0xDEADBEEF -> if_gnt c0, mem_req c1, if_rvalid c3 with 0xDEADBEEF, ls_rvalid 0.
REQ-039 Store ls_addr 0x40 wdata 0x12345678, mem_gnt delayed 3 cycles -> mem_req/mem_we/addr/wdata stable 4 cycles, single ls_rvalid, ls_rdata unchanged.
REQ-040 Both req every cycle, macro off -> LS granted each time, IF starved; macro on -> grants alternate IF, LS, IF, LS.
REQ-041 Spurious mem_rvalid in IDLE and mem_gnt in RSP -> no x_rvalid, no state change.
REQ-042 rst low during RSP, then mem_rvalid after release -> no x_rvalid, outputs at reset values, next request served normally.
